// File: rtl/cb.sv
// cb: registered PORT_N x PORT_N NoC crossbar with one round-robin arbiter per output.
// Grants are combinational; the winning flit appears on its output one clock later.
// Optional macro CB_LOCK_EN adds a per-output wormhole lock that keeps the current
// owner granted while it keeps requesting the same output.
module cb #(
   parameter int unsigned PORT_N = 5,
   parameter int unsigned FLIT_W = 34,
   localparam int unsigned PW = $clog2(PORT_N)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PORT_N*FLIT_W-1:0] cb_i,
   output logic [PORT_N*FLIT_W-1:0] cb_o,
   input  logic [PORT_N*PW-1:0]     port_i,
   input  logic [PORT_N-1:0]        req_i,
   output logic [PORT_N-1:0]        grt_o
);

   logic [PORT_N-1:0][PORT_N-1:0] req_m;    // req_m[o][i]: input i wants output o
   logic [PORT_N-1:0]             win_vld;
   logic [PORT_N-1:0][PW-1:0]     win_idx;
   logic [PORT_N-1:0]             lock_hit; // output kept by its locked owner this cycle
   logic [PORT_N-1:0][PW-1:0]     ptr_q, ptr_d;
   logic [PORT_N*FLIT_W-1:0]      cb_q, cb_d;
   logic [PORT_N-1:0]             grt;

`ifdef CB_LOCK_EN
   logic [PORT_N-1:0]             lock_q, lock_d;
   logic [PORT_N-1:0][PW-1:0]     own_q, own_d;
`endif

   // Request matrix and per-output winner selection (lock owner first, then round-robin).
   always_comb begin
      int idx;
      idx      = 0;
      req_m    = '0;
      win_vld  = '0;
      win_idx  = '0;
      lock_hit = '0;
      for (int o = 0; o < int'(PORT_N); o++) begin
         for (int i = 0; i < int'(PORT_N); i++) begin
            // Out-of-range destinations never match any o, so they are ignored.
            req_m[o][i] = req_i[i] && (port_i[i*PW +: PW] == PW'(o));
         end
      end
      for (int o = 0; o < int'(PORT_N); o++) begin
`ifdef CB_LOCK_EN
         if (lock_q[o] && req_m[o][own_q[o]]) begin
            lock_hit[o] = 1'b1;
            win_vld[o]  = 1'b1;
            win_idx[o]  = own_q[o];
         end
`endif
         if (!lock_hit[o]) begin
            for (int k = 0; k < int'(PORT_N); k++) begin
               idx = int'(ptr_q[o]) + k;
               if (idx >= int'(PORT_N)) idx = idx - int'(PORT_N);
               if (!win_vld[o] && req_m[o][idx]) begin
                  win_vld[o] = 1'b1;
                  win_idx[o] = PW'(idx);
               end
            end
         end
      end
   end

   // Grant vector back to the inputs; suppressed during reset.
   always_comb begin
      grt = '0;
      for (int o = 0; o < int'(PORT_N); o++) begin
         if (win_vld[o]) grt[win_idx[o]] = 1'b1;
      end
      grt_o = rst ? '0 : grt;
   end

   // Next output flits and round-robin pointers.
   always_comb begin
      int nxt;
      nxt   = 0;
      ptr_d = ptr_q;
      cb_d  = '0;
      for (int o = 0; o < int'(PORT_N); o++) begin
         if (win_vld[o]) begin
            cb_d[o*FLIT_W +: FLIT_W] = cb_i[int'(win_idx[o])*FLIT_W +: FLIT_W];
            nxt = int'(win_idx[o]) + 1;
            if (nxt >= int'(PORT_N)) nxt = 0;
            // A locked owner does not move the pointer; it already points past the owner.
            if (!lock_hit[o]) ptr_d[o] = PW'(nxt);
         end
      end
   end

   // Output and pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         cb_q  <= '0;
      end else begin
         ptr_q <= ptr_d;
         cb_q  <= cb_d;
      end
   end

   assign cb_o = cb_q;

`ifdef CB_LOCK_EN
   // Lock follows the winner; it drops as soon as the output has no winner or a new one.
   always_comb begin
      lock_d = win_vld;
      own_d  = own_q;
      for (int o = 0; o < int'(PORT_N); o++) begin
         if (win_vld[o]) own_d[o] = win_idx[o];
      end
   end

   // Lock state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q <= '0;
         own_q  <= '0;
      end else begin
         lock_q <= lock_d;
         own_q  <= own_d;
      end
   end
`endif

endmodule

// File: tb/tb_cb.sv
// tb_cb: directed bench for the cb crossbar. Grants are checked just after inputs
// settle; the expected output vector is queued and checked after the next edge.
module tb_cb;

   localparam int unsigned PORT_N = 5;
   localparam int unsigned FLIT_W = 34;
   localparam int unsigned PW     = 3;

   logic                     clk;
   logic                     rst;
   logic [PORT_N*FLIT_W-1:0] cb_i;
   logic [PORT_N*FLIT_W-1:0] cb_o;
   logic [PORT_N*PW-1:0]     port_i;
   logic [PORT_N-1:0]        req_i;
   logic [PORT_N-1:0]        grt_o;

   int checks   = 0;
   int failures = 0;

   logic [PW-1:0]            pv [PORT_N];
   logic [FLIT_W-1:0]        fv [PORT_N];
   logic [PORT_N*FLIT_W-1:0] sb [$];

   cb #(.PORT_N(PORT_N), .FLIT_W(FLIT_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .cb_i   (cb_i),
      .cb_o   (cb_o),
      .port_i (port_i),
      .req_i  (req_i),
      .grt_o  (grt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of requests from pv/fv, check grants, then check the registered flits.
   task automatic apply(input logic [PORT_N-1:0] req, input logic [PORT_N-1:0] exp_grt,
                        input string tag);
      logic [PORT_N*FLIT_W-1:0] exp_o;
      logic [PORT_N*FLIT_W-1:0] got_exp;
      @(negedge clk);
      req_i = req;
      for (int i = 0; i < int'(PORT_N); i++) begin
         port_i[i*PW +: PW]     = pv[i];
         cb_i[i*FLIT_W +: FLIT_W] = fv[i];
      end
      #1;
      checks++;
      assert (grt_o === exp_grt) else begin
         failures++;
         $error("FAIL %s grt observed=%b expected=%b", tag, grt_o, exp_grt);
      end
      exp_o = '0;
      for (int i = 0; i < int'(PORT_N); i++) begin
         if (exp_grt[i]) exp_o[int'(pv[i])*FLIT_W +: FLIT_W] = fv[i];
      end
      sb.push_back(exp_o);
      @(posedge clk);
      #1;
      got_exp = sb.pop_front();
      checks++;
      assert (cb_o === got_exp) else begin
         failures++;
         $error("FAIL %s cb_o observed=%h expected=%h", tag, cb_o, got_exp);
      end
   endtask

   task automatic idle(input string tag);
      apply('0, '0, tag);
   endtask

   initial begin
      rst    = 1'b1;
      req_i  = '0;
      port_i = '0;
      cb_i   = '0;

      // Reset held with random activity on the inputs.
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         req_i = PORT_N'($urandom);
         for (int i = 0; i < int'(PORT_N); i++) begin
            port_i[i*PW +: PW]       = PW'($urandom);
            cb_i[i*FLIT_W +: FLIT_W] = FLIT_W'({$urandom, $urandom});
         end
         #1;
         checks++;
         assert (grt_o === '0) else begin
            failures++;
            $error("FAIL reset_grt observed=%b expected=%b", grt_o, 5'b0);
         end
         @(posedge clk);
         #1;
         checks++;
         assert (cb_o === '0) else begin
            failures++;
            $error("FAIL reset_cb observed=%h expected=0", cb_o);
         end
      end
      @(negedge clk);
      req_i = '0;
      rst   = 1'b0;

      for (int i = 0; i < int'(PORT_N); i++) begin
         pv[i] = '0;
         fv[i] = FLIT_W'(32'h100 + i);
      end

      // Pointers start at 0: inputs 0 and 3 contend for output 2, input 0 wins.
      pv[0] = 3'd2; pv[3] = 3'd2;
      apply(5'b01001, 5'b00001, "reset_ptr");
      idle("idle_a");

      // Full parallel permutation.
      for (int i = 0; i < int'(PORT_N); i++) begin
         pv[i] = PW'(4 - i);
         fv[i] = FLIT_W'(32'h10 + i);
      end
      apply(5'b11111, 5'b11111, "parallel");
      idle("idle_b");

      // Contention on output 0 from inputs 1, 2, 4.
      for (int i = 0; i < int'(PORT_N); i++) pv[i] = '0;
      fv[1] = 34'h2_0000_0001; fv[2] = 34'h1_0000_0002; fv[4] = 34'h3_FFFF_FFF4;
`ifdef CB_LOCK_EN
      for (int n = 0; n < 6; n++) apply(5'b10110, 5'b00010, "fair_locked");
`else
      apply(5'b10110, 5'b00010, "fair_1a");
      apply(5'b10110, 5'b00100, "fair_2a");
      apply(5'b10110, 5'b10000, "fair_4a");
      apply(5'b10110, 5'b00010, "fair_1b");
      apply(5'b10110, 5'b00100, "fair_2b");
      apply(5'b10110, 5'b10000, "fair_4b");
`endif
      idle("idle_c");

      // Pointer wrap on output 1: ptr sits at 4, input 4 wins, ptr wraps to 0.
      pv[4] = 3'd1; fv[4] = 34'h0_DEAD_BEEF;
      apply(5'b10000, 5'b10000, "wrap_solo");
      idle("idle_d");
      pv[0] = 3'd1; fv[0] = 34'h1_CAFE_0000;
      apply(5'b10001, 5'b00001, "wrap_0");
      idle("idle_e");

      // Out-of-range destinations are ignored.
      pv[2] = 3'd6; pv[3] = 3'd5; fv[2] = 34'h0_0000_0AAA; fv[3] = 34'h0_0000_0BBB;
      apply(5'b01100, 5'b00000, "invalid_port");
      idle("idle_f");

      // Inputs 3 and 0 both request output 2 (ptr at 3), then input 3 drops.
      pv[0] = 3'd2; pv[3] = 3'd2; fv[0] = 34'h0_0000_00A0; fv[3] = 34'h0_0000_00B3;
`ifdef CB_LOCK_EN
      apply(5'b01001, 5'b01000, "lock_1");
      apply(5'b01001, 5'b01000, "lock_2");
      apply(5'b01001, 5'b01000, "lock_3");
      apply(5'b01001, 5'b01000, "lock_4");
`else
      apply(5'b01001, 5'b01000, "rr_3a");
      apply(5'b01001, 5'b00001, "rr_0a");
      apply(5'b01001, 5'b01000, "rr_3b");
      apply(5'b01001, 5'b00001, "rr_0b");
`endif
      apply(5'b00001, 5'b00001, "drop_3");
      idle("idle_g");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
